// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit with big-endian byte RAM and gpio register
// One request at a time: IDLE accepts, BUSY decodes/commits, RESP pulses rsp_valid.
module riscv_lsu #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [31:0] GPIO_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  gpio
);
  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_gpio;
  logic [7:0]  r_mem [MEM_BYTES];

  logic [1:0]    w_len_m1;
  logic [32:0]   w_last;
  logic          w_oor;
  logic          w_is_gpio;
  logic          w_bad_f3;
  logic          w_misal;
  logic          w_err;
  logic          w_commit;
  logic          w_mem_we;
  logic          w_gpio_we;
  logic [AW-1:0] w_i0, w_i1, w_i2, w_i3;
  logic [7:0]    w_b0, w_b1, w_b2, w_b3;
  logic [31:0]   w_ldata;

  assign req_ready = rst_n && (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign gpio      = r_gpio;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = BUSY;
      BUSY:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // 33-bit last-byte address so accesses near 2^32 cannot wrap back into RAM.
  assign w_len_m1  = (r_funct3[1:0] == 2'b00) ? 2'd0 :
                     (r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign w_last    = {1'b0, r_addr} + {31'b0, w_len_m1};
  assign w_oor     = (w_last >= 33'(MEM_BYTES));
  assign w_is_gpio = (r_addr == GPIO_ADDR);
  assign w_bad_f3  = r_we ? (r_funct3 > 3'b010)
                          : ((r_funct3 == 3'b011) || (r_funct3[2:1] == 2'b11));
  assign w_misal   = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_err     = w_bad_f3 || w_misal ||
                     (w_is_gpio ? (r_funct3 != 3'b010) : w_oor);

  // Gated by rst_n so a reset landing on the BUSY->RESP edge aborts the write.
  assign w_commit  = rst_n && (r_state == BUSY) && r_we && !w_err;
  assign w_mem_we  = w_commit && !w_is_gpio;
  assign w_gpio_we = w_commit && w_is_gpio;

  assign w_i0 = r_addr[AW-1:0];
  assign w_i1 = w_i0 + AW'(1);
  assign w_i2 = w_i0 + AW'(2);
  assign w_i3 = w_i0 + AW'(3);
  assign w_b0 = r_mem[w_i0];
  assign w_b1 = r_mem[w_i1];
  assign w_b2 = r_mem[w_i2];
  assign w_b3 = r_mem[w_i3];

  always_comb begin
    w_ldata = '0;
    if (!w_err && !r_we) begin
      if (w_is_gpio) begin
        w_ldata = {24'b0, r_gpio};
      end else begin
        case (r_funct3)
          3'b000:  w_ldata = {{24{w_b0[7]}}, w_b0};
          3'b001:  w_ldata = {{16{w_b0[7]}}, w_b0, w_b1};
          3'b010:  w_ldata = {w_b0, w_b1, w_b2, w_b3};
          3'b100:  w_ldata = {24'b0, w_b0};
          3'b101:  w_ldata = {16'b0, w_b0, w_b1};
          default: w_ldata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_gpio   <= '0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == BUSY) begin
        r_rdata <= w_ldata;
        r_err   <= w_err;
      end
      if (w_gpio_we) r_gpio <= r_wdata[7:0];
    end
  end

  // RAM has no reset; big-endian, so the lowest address takes the most significant byte.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      case (r_funct3[1:0])
        2'b00: r_mem[w_i0] <= r_wdata[7:0];
        2'b01: begin
          r_mem[w_i0] <= r_wdata[15:8];
          r_mem[w_i1] <= r_wdata[7:0];
        end
        default: begin
          r_mem[w_i0] <= r_wdata[31:24];
          r_mem[w_i1] <= r_wdata[23:16];
          r_mem[w_i2] <= r_wdata[15:8];
          r_mem[w_i3] <= r_wdata[7:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed self-checking bench for riscv_lsu
module tb_riscv_lsu;
  localparam logic [31:0] GPIO = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  gpio;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_lsu #(.MEM_BYTES(1024), .GPIO_ADDR(GPIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .gpio(gpio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request, checks the BUSY/RESP timing, returns the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      rd = '0;
      er = 1'b1;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("busy_no_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("resp_valid", {31'b0, rsp_valid}, 32'd1);
      rd = rsp_rdata;
      er = rsp_err;
    end
  endtask

  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    do_req(we, f3, addr, wd, rd, er);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_gpio", {24'b0, gpio}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, req_ready}, 32'd1);

    xfer("sw0",   1, 3'b010, 0, 32'h0001_F000, 32'h0, 0);
    xfer("lw0",   0, 3'b010, 0, 0, 32'h0001_F000, 0);
    xfer("lbu0",  0, 3'b100, 0, 0, 32'h00, 0);
    xfer("lbu1",  0, 3'b100, 1, 0, 32'h01, 0);
    xfer("lbu2",  0, 3'b100, 2, 0, 32'hF0, 0);
    xfer("lbu3",  0, 3'b100, 3, 0, 32'h00, 0);

    xfer("sw4",   1, 3'b010, 4, 32'hA1B2_C3D4, 32'h0, 0);
    xfer("sb5",   1, 3'b000, 5, 32'h1234_5680, 32'h0, 0);
    xfer("lb5",   0, 3'b000, 5, 0, 32'hFFFF_FF80, 0);
    xfer("lbu5",  0, 3'b100, 5, 0, 32'h0000_0080, 0);
    xfer("lw4a",  0, 3'b010, 4, 0, 32'hA180_C3D4, 0);
    xfer("sh6",   1, 3'b001, 6, 32'h0000_BEEF, 32'h0, 0);
    xfer("lh6",   0, 3'b001, 6, 0, 32'hFFFF_BEEF, 0);
    xfer("lhu6",  0, 3'b101, 6, 0, 32'h0000_BEEF, 0);
    xfer("lw4b",  0, 3'b010, 4, 0, 32'hA180_BEEF, 0);

    xfer("lh3",   0, 3'b001, 3, 0, 32'h0, 1);
    xfer("sw2",   1, 3'b010, 2, 32'hFFFF_FFFF, 32'h0, 1);
    xfer("lw0c",  0, 3'b010, 0, 0, 32'h0001_F000, 0);
    xfer("lw4c",  0, 3'b010, 4, 0, 32'hA180_BEEF, 0);

    xfer("sw1020", 1, 3'b010, 1020, 32'hCAFE_F00D, 32'h0, 0);
    xfer("lw1020", 0, 3'b010, 1020, 0, 32'hCAFE_F00D, 0);
    xfer("lw1022", 0, 3'b010, 1022, 0, 32'h0, 1);
    xfer("lh1022", 0, 3'b001, 1022, 0, 32'hFFFF_F00D, 0);
    xfer("lbu1023", 0, 3'b100, 1023, 0, 32'h0D, 0);
    xfer("lw1024", 0, 3'b010, 1024, 0, 32'h0, 1);
    xfer("sb1024", 1, 3'b000, 1024, 32'h11, 32'h0, 1);
    xfer("lwtop", 0, 3'b010, 32'hFFFF_FFFC, 0, 32'h0, 1);
    xfer("ld011", 0, 3'b011, 0, 0, 32'h0, 1);
    xfer("ld110", 0, 3'b110, 0, 0, 32'h0, 1);
    xfer("st011", 1, 3'b011, 0, 32'h5555_5555, 32'h0, 1);
    xfer("st100", 1, 3'b100, 0, 32'h5555_5555, 32'h0, 1);
    xfer("lw0d",  0, 3'b010, 0, 0, 32'h0001_F000, 0);

    xfer("swgpio", 1, 3'b010, GPIO, 32'h1234_56A5, 32'h0, 0);
    check("gpio_set", {24'b0, gpio}, 32'hA5);
    xfer("lwgpio", 0, 3'b010, GPIO, 0, 32'h0000_00A5, 0);
    xfer("sbgpio", 1, 3'b000, GPIO, 32'h0000_0011, 32'h0, 1);
    check("gpio_keep", {24'b0, gpio}, 32'hA5);
    xfer("lhgpio", 0, 3'b001, GPIO, 0, 32'h0, 1);
    xfer("lbugpio", 0, 3'b100, GPIO, 0, 32'h0, 1);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("hs_ready%0d", i), {31'b0, req_ready}, {31'b0, (i % 3) == 0});
      check($sformatf("hs_valid%0d", i), {31'b0, rsp_valid}, {31'b0, (i % 3) == 2});
      if ((i % 3) == 2) check($sformatf("hs_rdata%0d", i), rsp_rdata, 32'h0001_F000);
    end
    req_valid = 1'b0;

    xfer("sw8",   1, 3'b010, 8, 32'h1122_3344, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 8;
    req_wdata = 32'hDEAD_BEEF;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_rst_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    check("abort_gpio", {24'b0, gpio}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_no_valid%0d", i), {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    xfer("lw8",   0, 3'b010, 8, 0, 32'h1122_3344, 0);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 12;
    req_wdata = 32'h5566_7788;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rresp_valid", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rresp_drop", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    xfer("lw12",  0, 3'b010, 12, 0, 32'h5566_7788, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
